// File: rtl/cdc_hs_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_hs_arbiter
// Purpose  : Round-robin arbiter/sequencer that shares one multi-bit req/rsp
//            CDC handshake channel among NUM_REQ requesters in src_clk.
//            One requester is granted per transfer. Its {id, payload} is
//            presented on hs_din and a single-cycle hs_vld_in pulse is issued.
//            The arbiter then waits for hs_rdy_out or a timeout, and finally
//            holds a guard interval so the synchronised response can return
//            to zero before the next issue.
// Ports    : src_clk, src_rstn   - clock, async active-low reset
//            req_vld/req_data    - per-requester request level and payload
//            req_ack/req_err     - one-hot completion / timeout pulses
//            tmo_limit           - WAIT-cycle limit, 0 disables timeout
//            hs_vld_in/hs_din    - issue pulse and {id, payload} to handshake
//            hs_rdy_out          - completion pulse from handshake
//            busy, grant_id      - status
// Revision : 1.0 - initial release
// ============================================================================
module cdc_hs_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int TMO_W      = 10,
  parameter int GUARD_CYC  = 8
) (
  input  logic                          src_clk,
  input  logic                          src_rstn,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_err,
  input  logic [TMO_W-1:0]              tmo_limit,
  output logic                          hs_vld_in,
  output logic [ID_W+DATA_WIDTH-1:0]    hs_din,
  input  logic                          hs_rdy_out,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id
);

  localparam int                 c_gcnt_w     = $clog2(GUARD_CYC + 1);
  localparam logic [c_gcnt_w-1:0] c_guard_load = c_gcnt_w'(GUARD_CYC - 1);
  localparam logic [ID_W-1:0]     c_last_id    = ID_W'(NUM_REQ - 1);
  localparam logic [TMO_W-1:0]    c_tmo_max    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GUARD = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                       state_q,     state_d;
  logic [ID_W-1:0]              rr_ptr_q,    rr_ptr_d;
  logic [ID_W-1:0]              grant_id_q,  grant_id_d;
  logic [ID_W+DATA_WIDTH-1:0]   hs_din_q,    hs_din_d;
  logic                         hs_vld_in_q, hs_vld_in_d;
  logic [NUM_REQ-1:0]           req_ack_q,   req_ack_d;
  logic [NUM_REQ-1:0]           req_err_q,   req_err_d;
  logic                         busy_q,      busy_d;
  logic [TMO_W-1:0]             tmo_cnt_q,   tmo_cnt_d;
  logic [c_gcnt_w-1:0]          guard_cnt_q, guard_cnt_d;

  // --------------------------------------------------------------------------
  // Per-requester payload slices and one-hot decode of the current grant
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic [NUM_REQ-1:0]    w_grant_onehot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_slice[g]        = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_grant_onehot[g] = (grant_id_q == ID_W'(g));
  end

  // --------------------------------------------------------------------------
  // Round-robin pick: first set req_vld bit at or above rr_ptr, wrapping.
  // The inner loop compares against a constant j so only real requester
  // indices are ever addressed, even when NUM_REQ is not a power of two.
  // --------------------------------------------------------------------------
  logic                  w_found;
  logic [ID_W-1:0]       w_pick;
  logic [DATA_WIDTH-1:0] w_pick_data;
  int                    w_idx;

  always_comb begin
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_data = '0;
    w_idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(rr_ptr_q) + i;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && (j == w_idx) && req_vld[j]) begin
          w_found     = 1'b1;
          w_pick      = ID_W'(j);
          w_pick_data = w_slice[j];
        end
      end
    end
  end

  // Timeout fires on the WAIT cycle whose count equals limit-1.
  logic w_tmo_hit;
  assign w_tmo_hit = (tmo_limit != '0) && (tmo_cnt_q == (tmo_limit - 1'b1));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    hs_din_d    = hs_din_q;
    tmo_cnt_d   = tmo_cnt_q;
    guard_cnt_d = guard_cnt_q;
    hs_vld_in_d = 1'b0;
    req_ack_d   = '0;
    req_err_d   = '0;

    case (state_q)
      IDLE: begin
        if (w_found) begin
          state_d    = ISSUE;
          grant_id_d = w_pick;
          hs_din_d   = {w_pick, w_pick_data};
        end
      end

      ISSUE: begin
        // Registered, so the pulse appears on the cycle after ISSUE.
        hs_vld_in_d = 1'b1;
        tmo_cnt_d   = '0;
        state_d     = WAIT;
      end

      WAIT: begin
        // Ack has priority over a coincident timeout.
        if (hs_rdy_out) begin
          req_ack_d = w_grant_onehot;
          state_d   = GUARD;
        end else if (w_tmo_hit) begin
          req_err_d = w_grant_onehot;
          state_d   = GUARD;
        end else if (tmo_cnt_q != c_tmo_max) begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        if (state_d == GUARD) begin
          guard_cnt_d = c_guard_load;
          rr_ptr_d    = (grant_id_q == c_last_id) ? '0 : grant_id_q + 1'b1;
        end
      end

      GUARD: begin
        // hs_rdy_out is deliberately ignored here: any pulse is stale.
        if (guard_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Derived from the next state so the registered flag tracks state_q.
    busy_d = (state_d != IDLE);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge src_clk or negedge src_rstn) begin
    if (!src_rstn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      hs_din_q    <= '0;
      hs_vld_in_q <= 1'b0;
      req_ack_q   <= '0;
      req_err_q   <= '0;
      busy_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      hs_din_q    <= hs_din_d;
      hs_vld_in_q <= hs_vld_in_d;
      req_ack_q   <= req_ack_d;
      req_err_q   <= req_err_d;
      busy_q      <= busy_d;
      tmo_cnt_q   <= tmo_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  assign req_ack   = req_ack_q;
  assign req_err   = req_err_q;
  assign hs_vld_in = hs_vld_in_q;
  assign hs_din    = hs_din_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;

endmodule
`default_nettype wire
